// File: rtl/tow_match_scorer_pkg.sv
// Shared state encoding and width helper for the tug-of-war match scorer.
package tow_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_RST   = 3'd0,
        ST_PLAY  = 3'd1,
        ST_WIN_L = 3'd2,
        ST_WIN_R = 3'd3,
        ST_MATCH = 3'd4,
        ST_ERR   = 3'd5
    } tow_state_e;

    // Signed rope-position width able to hold the +/-(half+1) overshoot value.
    function automatic int pos_width(input int half);
        return $clog2(half + 2) + 1;
    endfunction

endpackage

// File: rtl/tow_match_scorer_if.sv
// Push-arbiter inputs and display-side outputs of the tug-of-war match scorer.
interface tow_match_scorer_if #(
    parameter int HALF          = 3,
    parameter int ROUNDS_TO_WIN = 2
);
    localparam int W  = 2 * HALF + 1;
    localparam int RW = $clog2(ROUNDS_TO_WIN + 1);

    // Qualified one-cycle pulse interface: winrnd marks a resolved push and is ignored while tie=1;
    // there is no back-pressure, the scorer accepts every qualified push in the cycle it appears.
    logic          winrnd;
    logic          right;
    logic          leds_on;
    logic          tie;
    logic          clr_match;
    logic [W-1:0]  score;
    logic [RW-1:0] rounds_l;
    logic [RW-1:0] rounds_r;
    logic          match_over;
    logic          winner_r;

    modport master (
        output winrnd, right, leds_on, tie, clr_match,
        input  score, rounds_l, rounds_r, match_over, winner_r
    );

    modport slave (
        input  winrnd, right, leds_on, tie, clr_match,
        output score, rounds_l, rounds_r, match_over, winner_r
    );

endinterface

// File: rtl/tow_match_scorer_decode.sv
// Combinational LED-pattern decode of scorer state and rope position.
module tow_score_decode
    import tow_pkg::*;
#(
    parameter int HALF = 3
) (
    input  tow_state_e                          state,
    input  logic signed [pos_width(HALF)-1:0]   pos,
    input  logic                                winner_r,
    output logic [2*HALF:0]                     score
);

    localparam int W = 2 * HALF + 1;
    localparam logic [W-1:0] RIGHT_PAT = {{(HALF + 1){1'b0}}, {HALF{1'b1}}};
    localparam logic [W-1:0] LEFT_PAT  = {{HALF{1'b1}}, {(HALF + 1){1'b0}}};

    always_comb begin
        score = '0;
        case (state)
            ST_RST: begin
                score[W-1] = 1'b1;
                score[W-2] = 1'b1;
                score[1]   = 1'b1;
                score[0]   = 1'b1;
            end
            // Positive pos pulls the lit LED toward bit 0 (right side).
            ST_PLAY: begin
                for (int i = 0; i < W; i++) begin
                    score[i] = (i == HALF - int'(pos));
                end
            end
            ST_WIN_L: score = LEFT_PAT;
            ST_WIN_R: score = RIGHT_PAT;
            ST_MATCH: score = winner_r ? RIGHT_PAT : LEFT_PAT;
            default: begin
                for (int i = 0; i < W; i++) begin
                    score[i] = ((W - 1 - i) % 2 == 0);
                end
            end
        endcase
    end

endmodule

// File: rtl/tow_match_scorer.sv
// Tug-of-war round/match scorer. Optional TOW_FAVOUR_LOSER_EN lets the trailing player's
// proper push at the rope end jump two steps back toward centre.
module tow_match_scorer
    import tow_pkg::*;
#(
    parameter int HALF          = 3,
    parameter int ROUNDS_TO_WIN = 2
) (
    input logic                clk,
    input logic                rst,
    tow_match_scorer_if.slave  bus
);

    localparam int W  = 2 * HALF + 1;
    localparam int RW = $clog2(ROUNDS_TO_WIN + 1);
    localparam int PW = pos_width(HALF);

    localparam logic signed [PW-1:0] P_ONE  = PW'(1);
    localparam logic signed [PW-1:0] P_MAX  = PW'(HALF);
    localparam logic signed [PW-1:0] P_OVER = PW'(HALF + 1);
    localparam logic signed [PW-1:0] P_FAV  = PW'(HALF - 2);
    localparam logic [RW-1:0]        R_MAX  = RW'(ROUNDS_TO_WIN);

    tow_state_e           state, state_n;
    logic signed [PW-1:0] pos, pos_n, moved;
    logic [RW-1:0]        rounds_l, rounds_l_n, rounds_r, rounds_r_n;
    logic                 winner_r, winner_r_n;
    logic                 push, mr, favour;
    logic [W-1:0]         score_w;

    assign push  = bus.winrnd & ~bus.tie;
    // Jumping the light moves the rope toward the opponent.
    assign mr    = (bus.right & bus.leds_on) | (~bus.right & ~bus.leds_on);
    assign moved = mr ? (pos + P_ONE) : (pos - P_ONE);

`ifdef TOW_FAVOUR_LOSER_EN
    assign favour = bus.leds_on &
                    (((pos == -P_MAX) & bus.right) | ((pos == P_MAX) & ~bus.right));
`else
    assign favour = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RST;
            pos      <= '0;
            rounds_l <= '0;
            rounds_r <= '0;
            winner_r <= 1'b0;
        end else begin
            state    <= state_n;
            pos      <= pos_n;
            rounds_l <= rounds_l_n;
            rounds_r <= rounds_r_n;
            winner_r <= winner_r_n;
        end
    end

    always_comb begin
        state_n    = state;
        pos_n      = pos;
        rounds_l_n = rounds_l;
        rounds_r_n = rounds_r;
        winner_r_n = winner_r;
        if (bus.clr_match) begin
            state_n    = ST_RST;
            pos_n      = '0;
            rounds_l_n = '0;
            rounds_r_n = '0;
            winner_r_n = 1'b0;
        end else begin
            case (state)
                ST_RST: begin
                    if (push) begin
                        state_n = ST_PLAY;
                        pos_n   = '0;
                    end
                end
                ST_PLAY: begin
                    if (push) begin
                        if (favour) begin
                            pos_n = pos[PW-1] ? -P_FAV : P_FAV;
                        end else if (moved == P_OVER) begin
                            state_n    = ST_WIN_R;
                            rounds_r_n = (rounds_r == R_MAX) ? rounds_r : rounds_r + RW'(1);
                        end else if (moved == -P_OVER) begin
                            state_n    = ST_WIN_L;
                            rounds_l_n = (rounds_l == R_MAX) ? rounds_l : rounds_l + RW'(1);
                        end else begin
                            pos_n = moved;
                        end
                    end
                end
                // Counter was already bumped on entry, so the match decision is one cycle later.
                ST_WIN_L: begin
                    if (rounds_l == R_MAX) begin
                        state_n    = ST_MATCH;
                        winner_r_n = 1'b0;
                    end else if (push) begin
                        state_n = ST_PLAY;
                        pos_n   = '0;
                    end
                end
                ST_WIN_R: begin
                    if (rounds_r == R_MAX) begin
                        state_n    = ST_MATCH;
                        winner_r_n = 1'b1;
                    end else if (push) begin
                        state_n = ST_PLAY;
                        pos_n   = '0;
                    end
                end
                ST_MATCH: state_n = ST_MATCH;
                ST_ERR:   state_n = ST_ERR;
                default:  state_n = ST_ERR;
            endcase
        end
    end

    tow_score_decode #(.HALF(HALF)) u_decode (
        .state    (state),
        .pos      (pos),
        .winner_r (winner_r),
        .score    (score_w)
    );

    assign bus.score      = score_w;
    assign bus.rounds_l   = rounds_l;
    assign bus.rounds_r   = rounds_r;
    assign bus.match_over = (state == ST_MATCH);
    assign bus.winner_r   = winner_r;

endmodule

// File: tb/tb_tow_match_scorer.sv
// Directed and random bench for tow_match_scorer; the reference model follows TOW_FAVOUR_LOSER_EN.
module tb_tow_match_scorer;

    localparam int HALF = 3;
    localparam int RTW  = 2;
    localparam int W    = 2 * HALF + 1;
    localparam int RW   = $clog2(RTW + 1);

    localparam int P_IDLE = 0;
    localparam int P_LIVE = 1;
    localparam int P_WONL = 2;
    localparam int P_WONR = 3;
    localparam int P_DONE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int m_ph  = P_IDLE;
    int m_pos = 0;
    int m_rl  = 0;
    int m_rr  = 0;
    bit m_win = 1'b0;

    logic [W-1:0] exp_q[$];

    tow_match_scorer_if #(.HALF(HALF), .ROUNDS_TO_WIN(RTW)) bus();

    tow_match_scorer #(.HALF(HALF), .ROUNDS_TO_WIN(RTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_score();
        logic [W-1:0] one;
        logic [W-1:0] low;
        one = 1;
        low = (one << HALF) - one;
        case (m_ph)
            P_IDLE:  return (one << (W - 1)) | (one << (W - 2)) | (one << 1) | one;
            P_LIVE:  return one << (HALF - m_pos);
            P_WONL:  return low << (HALF + 1);
            P_WONR:  return low;
            default: return m_win ? low : (low << (HALF + 1));
        endcase
    endfunction

    task automatic model_step(input bit wr, input bit rt, input bit lo, input bit ti,
                              input bit cm, input bit rs);
        bit push;
        int np;
        push = wr && !ti;
        if (rs || cm) begin
            m_ph = P_IDLE; m_pos = 0; m_rl = 0; m_rr = 0; m_win = 1'b0;
        end else begin
            case (m_ph)
                P_IDLE: if (push) begin m_ph = P_LIVE; m_pos = 0; end
                P_LIVE: if (push) begin
                    np = m_pos + ((rt == lo) ? 1 : -1);
`ifdef TOW_FAVOUR_LOSER_EN
                    if (lo && ((m_pos == -HALF && rt) || (m_pos == HALF && !rt)))
                        np = (m_pos < 0) ? -(HALF - 2) : (HALF - 2);
`endif
                    if (np > HALF) begin m_rr++; m_ph = P_WONR; end
                    else if (np < -HALF) begin m_rl++; m_ph = P_WONL; end
                    else m_pos = np;
                end
                P_WONL: begin
                    if (m_rl >= RTW) begin m_ph = P_DONE; m_win = 1'b0; end
                    else if (push) begin m_ph = P_LIVE; m_pos = 0; end
                end
                P_WONR: begin
                    if (m_rr >= RTW) begin m_ph = P_DONE; m_win = 1'b1; end
                    else if (push) begin m_ph = P_LIVE; m_pos = 0; end
                end
                default: ;
            endcase
        end
        exp_q.push_back(exp_score());
    endtask

    task automatic compare_all(input string tag);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check({tag, ".score"}, 32'(bus.score), 32'(e));
        check({tag, ".rounds_l"}, 32'(bus.rounds_l), 32'(m_rl));
        check({tag, ".rounds_r"}, 32'(bus.rounds_r), 32'(m_rr));
        check({tag, ".match_over"}, 32'(bus.match_over), 32'(m_ph == P_DONE));
        if (m_ph == P_DONE) check({tag, ".winner_r"}, 32'(bus.winner_r), 32'(m_win));
    endtask

    task automatic step(input string tag, input bit wr, input bit rt, input bit lo,
                        input bit ti, input bit cm, input bit rs);
        bus.winrnd = wr; bus.right = rt; bus.leds_on = lo;
        bus.tie = ti; bus.clr_match = cm; rst = rs;
        @(posedge clk);
        model_step(wr, rt, lo, ti, cm, rs);
        #1;
        compare_all(tag);
    endtask

    initial begin
        logic [W-1:0] walk [4];
        bit bias;
        walk[0] = 7'b0000100; walk[1] = 7'b0000010; walk[2] = 7'b0000001; walk[3] = 7'b0000111;
        bus.winrnd = 0; bus.right = 0; bus.leds_on = 0; bus.tie = 0; bus.clr_match = 0;

        step("reset", 0, 0, 0, 0, 0, 1);
        check("reset_pattern", 32'(bus.score), 32'(7'b1100011));
        step("idle", 0, 0, 0, 0, 0, 0);

        step("arm", 1, 1, 1, 0, 0, 0);
        check("arm_pattern", 32'(bus.score), 32'(7'b0001000));
        for (int i = 0; i < 4; i++) begin
            step("right_walk", 1, 1, 1, 0, 0, 0);
            check("right_walk_pattern", 32'(bus.score), 32'(walk[i]));
        end
        check("first_round_r", 32'(bus.rounds_r), 32'd1);

        step("rearm", 1, 1, 1, 0, 0, 0);
        step("tie_push", 1, 1, 1, 1, 0, 0);
        check("tie_pattern", 32'(bus.score), 32'(7'b0001000));
        step("left_jump", 1, 0, 0, 0, 0, 0);
        check("left_jump_pattern", 32'(bus.score), 32'(7'b0000100));
        step("to_plus2", 1, 1, 1, 0, 0, 0);
        step("mid_reset", 0, 0, 0, 0, 0, 1);
        check("mid_reset_pattern", 32'(bus.score), 32'(7'b1100011));

        step("fav_arm", 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("left_walk", 1, 0, 1, 0, 0, 0);
        check("left_end_pattern", 32'(bus.score), 32'(7'b1000000));
        step("fav_push", 1, 1, 1, 0, 0, 0);
`ifdef TOW_FAVOUR_LOSER_EN
        check("fav_pattern", 32'(bus.score), 32'(7'b0010000));
`else
        check("fav_pattern", 32'(bus.score), 32'(7'b0100000));
`endif

        step("m_reset", 0, 0, 0, 0, 0, 1);
        for (int r = 0; r < RTW; r++) begin
            step("m_arm", 1, 1, 1, 0, 0, 0);
            for (int i = 0; i < 4; i++) step("m_right", 1, 1, 1, 0, 0, 0);
        end
        step("m_decide", 0, 0, 0, 0, 0, 0);
        check("match_over_r", 32'(bus.match_over), 32'd1);
        check("winner_r_r", 32'(bus.winner_r), 32'd1);
        for (int i = 0; i < 3; i++) step("m_ignore", 1, i[0], 1, 0, 0, 0);
        step("m_clear", 1, 1, 1, 0, 1, 0);
        check("clear_pattern", 32'(bus.score), 32'(7'b1100011));

        for (int r = 0; r < RTW; r++) begin
            step("l_arm", 1, 0, 1, 0, 0, 0);
            for (int i = 0; i < 4; i++) step("l_left", 1, 0, 1, 0, 0, 0);
        end
        step("l_decide", 0, 0, 0, 0, 0, 0);
        check("left_match_pattern", 32'(bus.score), 32'(7'b1110000));
        check("winner_r_l", 32'(bus.winner_r), 32'd0);
        step("l_clear", 0, 0, 0, 0, 1, 0);

        bias = 0;
        for (int n = 0; n < 1200; n++) begin
            bit wr, rt, lo, ti, cm, rs;
            if (n % 50 == 0) bias = $urandom_range(0, 1);
            wr = $urandom_range(0, 1);
            rt = ($urandom_range(0, 3) != 0) ^ bias;
            lo = ($urandom_range(0, 4) != 0);
            ti = ($urandom_range(0, 6) == 0);
            cm = ($urandom_range(0, 80) == 0);
            rs = ($urandom_range(0, 200) == 0);
            step("random", wr, rt, lo, ti, cm, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
